tmds_line_sched: RTL and testbench

//  Per-line transmit scheduler behind tmds_timing in the HDMI-to-Ethernet send path.
//  - Detects the end of each active video line and queues a line descriptor {frame, vcnt}.
//  - Arbitrates queued video lines against an aux (audio/infoframe) requester.
//  - Issues one job at a time to the Ethernet TX engine with a req/ack/done handshake.
//  - Enforces an inter-frame gap between jobs.

---
 rtl/tmds_line_sched.sv | 218 +++++++++++++++++++++
 tb/tb_tmds_line_sched.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_line_sched.sv
// tmds_line_sched
//   Per-line transmit scheduler that sits behind tmds_timing in the
//   HDMI-to-Ethernet send path. It queues one descriptor {frame, line} per
//   active video line and arbitrates those lines against an aux
//   (audio/infoframe) requester. It hands one job at a time to the Ethernet
//   TX engine over a req/ack/done handshake, and it leaves an inter-frame
//   gap after every job.
//
// Ports
//   rx0_pclk    in   pixel clock, the only clock
//   rstbtn_n    in   asynchronous reset, active HIGH despite the name
//   rx0_vsync   in   vsync from the TMDS decoder (frame tag source)
//   video_en    in   active-pixel flag from tmds_timing
//   video_vcnt  in   [10:0] line counter from tmds_timing
//   aux_req     in   aux job request, level, held until aux_grant
//   aux_grant   out  1-cycle pulse after the engine accepts the aux job
//   tx_req      out  job request to the TX engine
//   tx_is_aux   out  1 = aux job, 0 = video line job (valid with tx_req)
//   tx_line     out  [10:0] line number of a video job (valid with tx_req)
//   tx_frame    out  [7:0] frame tag of a video job (valid with tx_req)
//   tx_ack      in   engine accepted the job (1 cycle)
//   tx_done     in   engine finished the job (1 cycle)
//   line_drop   out  1-cycle pulse when a line is discarded (queue full)
//   drop_cnt    out  [15:0] saturating count of dropped lines
//                    (present only when DROP_CNT_EN is defined)
//
// Parameters
//   QDEPTH   descriptor queue depth, power of 2, >= 2
//   IFG_CYC  idle cycles after tx_done before the next issue (0 = none)
//   AUX_MAX  video grants allowed while aux_req waits before aux is forced
//
// Build option
//   DROP_CNT_EN  adds the drop_cnt output and its counter.

module tmds_line_sched #(
  parameter int QDEPTH  = 4,
  parameter int IFG_CYC = 12,
  parameter int AUX_MAX = 8
) (
  input  logic        rx0_pclk,
  input  logic        rstbtn_n,
  input  logic        rx0_vsync,
  input  logic        video_en,
  input  logic [10:0] video_vcnt,
  input  logic        aux_req,
  output logic        aux_grant,
  output logic        tx_req,
  output logic        tx_is_aux,
  output logic [10:0] tx_line,
  output logic [7:0]  tx_frame,
  input  logic        tx_ack,
  input  logic        tx_done,
  output logic        line_drop
`ifdef DROP_CNT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int QA  = (QDEPTH < 2) ? 1 : $clog2(QDEPTH);
  localparam int QCW = QA + 1;
  localparam int SW  = (AUX_MAX < 1) ? 1 : $clog2(AUX_MAX + 1);
  localparam int GW  = (IFG_CYC < 2) ? 1 : $clog2(IFG_CYC + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, GAP} state_t;

  state_t          state, state_next;
  logic            vsync_d;
  logic            video_en_d;
  logic [10:0]     vcnt_d;
  logic [7:0]      frame_cnt;
  logic [18:0]     mem [QDEPTH];
  logic [QA-1:0]   wr_ptr, rd_ptr;
  logic [QCW-1:0]  q_count;
  logic [SW-1:0]   starve_cnt;
  logic [GW-1:0]   gap_cnt;
  logic            sel_aux;
  logic            aux_grant_r;
  logic            line_drop_r;

  logic            line_end;
  logic            q_full, q_empty;
  logic            push, pop;
  logic            aux_sel;
  logic [18:0]     head;

  // A line ends on the first inactive cycle that follows an active one.
  assign line_end = video_en_d & ~video_en;
  assign q_full   = (q_count == QCW'(QDEPTH));
  assign q_empty  = (q_count == '0);
  // Full is judged before any same-cycle pop, so a pop never makes room
  // for a push that lands in the same cycle.
  assign push     = line_end & ~q_full;
  assign pop      = (state == ISSUE) & tx_ack & ~sel_aux;
  assign head     = mem[rd_ptr];
  // Aux wins only if there is no video waiting or video has starved it
  // for AUX_MAX grants.
  assign aux_sel  = aux_req & (q_empty | (starve_cnt == SW'(AUX_MAX)));

  assign aux_grant = aux_grant_r;
  assign line_drop = line_drop_r;

  // Input pipeline and frame counter.
  always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
    if (rstbtn_n) begin
      vsync_d    <= 1'b0;
      video_en_d <= 1'b0;
      vcnt_d     <= '0;
      frame_cnt  <= '0;
    end else begin
      vsync_d    <= rx0_vsync;
      video_en_d <= video_en;
      vcnt_d     <= video_vcnt;
      if (rx0_vsync & ~vsync_d)
        frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Descriptor storage carries no reset; validity lives in q_count.
  always_ff @(posedge rx0_pclk) begin
    if (push)
      mem[wr_ptr] <= {frame_cnt, vcnt_d};
  end

  always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
    if (rstbtn_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      q_count     <= '0;
      line_drop_r <= 1'b0;
    end else begin
      line_drop_r <= line_end & q_full;
      if (push)
        wr_ptr <= wr_ptr + QA'(1);
      if (pop)
        rd_ptr <= rd_ptr + QA'(1);
      case ({push, pop})
        2'b10:   q_count <= q_count + QCW'(1);
        2'b01:   q_count <= q_count - QCW'(1);
        default: q_count <= q_count;
      endcase
    end
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
    if (rstbtn_n)
      drop_cnt <= '0;
    else if (line_end & q_full & (drop_cnt != 16'hFFFF))
      drop_cnt <= drop_cnt + 16'd1;
  end
`endif

  // FSM state register.
  always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
    if (rstbtn_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (~q_empty | aux_req) state_next = ISSUE;
      ISSUE: if (tx_ack) state_next = BUSY;
      BUSY:  if (tx_done) state_next = (IFG_CYC == 0) ? IDLE : GAP;
      // gap_cnt is loaded with IFG_CYC, so GAP lasts exactly IFG_CYC cycles.
      GAP:   if (gap_cnt <= GW'(1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: the job fields come straight from state, the latched
  // selection and the queue head, so they stay stable throughout ISSUE.
  always_comb begin
    tx_req    = 1'b0;
    tx_is_aux = 1'b0;
    tx_line   = '0;
    tx_frame  = '0;
    if (state == ISSUE) begin
      tx_req    = 1'b1;
      tx_is_aux = sel_aux;
      if (~sel_aux) begin
        tx_line  = head[10:0];
        tx_frame = head[18:11];
      end
    end
  end

  // Job selection, starvation tracking, gap timer, and the aux grant.
  always_ff @(posedge rx0_pclk or posedge rstbtn_n) begin
    if (rstbtn_n) begin
      sel_aux     <= 1'b0;
      starve_cnt  <= '0;
      gap_cnt     <= '0;
      aux_grant_r <= 1'b0;
    end else begin
      aux_grant_r <= 1'b0;
      if (state == IDLE)
        sel_aux <= aux_sel;
      if ((state == ISSUE) & tx_ack) begin
        if (sel_aux) begin
          aux_grant_r <= 1'b1;
          starve_cnt  <= '0;
        end else if (aux_req & (starve_cnt != SW'(AUX_MAX))) begin
          starve_cnt <= starve_cnt + SW'(1);
        end
      end
      if ((state == BUSY) & tx_done)
        gap_cnt <= GW'(IFG_CYC);
      else if ((state == GAP) & (gap_cnt != '0))
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

endmodule

// File: tb/tb_tmds_line_sched.sv
// tb_tmds_line_sched
//   Directed bench for tmds_line_sched with its default parameters
//   (QDEPTH=4, IFG_CYC=12, AUX_MAX=8). It covers the following:
//   - first-line latency
//   - queue overflow and drop reporting
//   - aux starvation forcing
//   - inter-frame gap timing
//   - frame tag wrap
//   - asynchronous reset in the ISSUE and BUSY states
//   The expected values are hand-computed constants.

module tb_tmds_line_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vsync = 1'b0;
  logic        video_en = 1'b0;
  logic [10:0] vcnt = '0;
  logic        aux_req = 1'b0;
  logic        tx_ack = 1'b0;
  logic        tx_done = 1'b0;
  logic        aux_grant, tx_req, tx_is_aux, line_drop;
  logic [10:0] tx_line;
  logic [7:0]  tx_frame;
`ifdef DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  tmds_line_sched dut (
    .rx0_pclk   (clk),
    .rstbtn_n   (rst),
    .rx0_vsync  (vsync),
    .video_en   (video_en),
    .video_vcnt (vcnt),
    .aux_req    (aux_req),
    .aux_grant  (aux_grant),
    .tx_req     (tx_req),
    .tx_is_aux  (tx_is_aux),
    .tx_line    (tx_line),
    .tx_frame   (tx_frame),
    .tx_ack     (tx_ack),
    .tx_done    (tx_done),
    .line_drop  (line_drop)
`ifdef DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is raised between clock edges; outputs must clear without an edge.
  task automatic do_reset(input string tag);
    vsync    = 1'b0;
    video_en = 1'b0;
    vcnt     = '0;
    aux_req  = 1'b0;
    tx_ack   = 1'b0;
    tx_done  = 1'b0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_req"}, {31'd0, tx_req}, 32'd0);
    check({tag, "_grant"}, {31'd0, aux_grant}, 32'd0);
    check({tag, "_drop"}, {31'd0, line_drop}, 32'd0);
    tick();
    rst = 1'b0;
  endtask

  // Two active cycles then the line-end cycle; returns in the cycle after it.
  task automatic line_end(input logic [10:0] v);
    video_en = 1'b1;
    vcnt     = v;
    tick();
    tick();
    video_en = 1'b0;
    tick();
  endtask

  task automatic vsync_edges(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b1;
      tick();
      vsync = 1'b0;
      tick();
    end
  endtask

  task automatic wait_req(input string tag, input int max_cyc);
    int n;
    n = 0;
    while (!tx_req && n < max_cyc) begin
      tick();
      n++;
    end
    check({tag, "_req_seen"}, {31'd0, tx_req}, 32'd1);
  endtask

  task automatic idle_check(input string tag, input int n);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (tx_req) seen = 1'b1;
    end
    check(tag, {31'd0, seen}, 32'd0);
  endtask

  // Run one job through the engine handshake and check its fields.
  task automatic do_job(input logic exp_aux, input logic [10:0] el,
                        input logic [7:0] ef, input string tag);
    wait_req(tag, 60);
    check({tag, "_is_aux"}, {31'd0, tx_is_aux}, {31'd0, exp_aux});
    if (!exp_aux) begin
      check({tag, "_line"}, {21'd0, tx_line}, {21'd0, el});
      check({tag, "_frame"}, {24'd0, tx_frame}, {24'd0, ef});
    end
    $display("job %s: aux=%0d line=%0d frame=%0d", tag, tx_is_aux, tx_line, tx_frame);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check({tag, "_req_drop"}, {31'd0, tx_req}, 32'd0);
    check({tag, "_grant"}, {31'd0, aux_grant}, {31'd0, exp_aux});
    if (exp_aux) aux_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;

    // 1: first-line latency after a long active line.
    do_reset("t1_rst");
    video_en = 1'b1;
    vcnt     = 11'd5;
    repeat (1280) tick();
    video_en = 1'b0;
    tick();
    check("t1_req_n1", {31'd0, tx_req}, 32'd0);
    tick();
    check("t1_req_n2", {31'd0, tx_req}, 32'd1);
    do_job(1'b0, 11'd5, 8'd0, "t1_job");

    // 2: five line ends with no ack; the fifth is dropped.
    do_reset("t2_rst");
    for (int i = 0; i < 4; i++) begin
      line_end(11'(10 + i));
      check($sformatf("t2_nodrop%0d", i), {31'd0, line_drop}, 32'd0);
    end
    line_end(11'd14);
    check("t2_drop", {31'd0, line_drop}, 32'd1);
`ifdef DROP_CNT_EN
    check("t2_drop_cnt", {16'd0, drop_cnt}, 32'd1);
`endif
    tick();
    check("t2_drop_pulse_end", {31'd0, line_drop}, 32'd0);
    for (int i = 0; i < 4; i++)
      do_job(1'b0, 11'(10 + i), 8'd0, $sformatf("t2_job%0d", i));
    idle_check("t2_queue_empty", 30);

    // 3: aux starved by 8 video jobs, then forced ahead of lines 8 and 9.
    do_reset("t3_rst");
    for (int i = 0; i < 4; i++) line_end(11'(i));
    aux_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_job(1'b0, 11'(k), 8'd0, $sformatf("t3_vid%0d", k));
      if (k < 6) line_end(11'(k + 4));
    end
    do_job(1'b1, 11'd0, 8'd0, "t3_aux");
    do_job(1'b0, 11'd8, 8'd0, "t3_vid8");
    do_job(1'b0, 11'd9, 8'd0, "t3_vid9");

    // 4: tx_req returns exactly 14 cycles after tx_done.
    do_reset("t4_rst");
    line_end(11'd1);
    line_end(11'd2);
    wait_req("t4_first", 20);
    check("t4_first_line", {21'd0, tx_line}, 32'd1);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    tick();
    tx_done = 1'b1;
    cnt = 0;
    do begin
      tick();
      tx_done = 1'b0;
      cnt++;
    end while (!tx_req && cnt < 40);
    check("t4_ifg_cycles", cnt, 32'd14);
    $display("ifg: tx_req after %0d cycles", cnt);
    do_job(1'b0, 11'd2, 8'd0, "t4_second");

    // 5: frame tag reaches 255, then wraps to 0.
    do_reset("t5_rst");
    vsync_edges(255);
    line_end(11'd7);
    do_job(1'b0, 11'd7, 8'd255, "t5_f255");
    vsync_edges(1);
    line_end(11'd8);
    do_job(1'b0, 11'd8, 8'd0, "t5_wrap");

    // 6a: asynchronous reset while a request is pending.
    do_reset("t6_rst");
    vsync_edges(3);
    line_end(11'd20);
    line_end(11'd21);
    wait_req("t6_issue", 20);
    do_reset("t6_async_issue");
    idle_check("t6a_queue_empty", 20);

    // 6b: asynchronous reset while BUSY with lines still queued.
    vsync_edges(3);
    line_end(11'd20);
    line_end(11'd21);
    line_end(11'd22);
    wait_req("t6_busy", 20);
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
    check("t6_in_busy", {31'd0, tx_req}, 32'd0);
    do_reset("t6_async_busy");
    idle_check("t6b_queue_empty", 20);
    line_end(11'd33);
    do_job(1'b0, 11'd33, 8'd0, "t6_after");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
